// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the memory cycle sequencer.
// Imported by mem_seq_wait_ctr and mem_cycle_sequencer.
package mem_seq_pkg;
  localparam int DEV_W      = 2;
  localparam int WAIT_CTR_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_e;
endpackage

// File: rtl/mem_seq_wait_ctr.sv
// Strobe-length down-counter plus external-wait extension counter.
// done_o marks the last base STROBE cycle; timeout_o marks exhausted extensions.
module mem_seq_wait_ctr
  import mem_seq_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic run_i,
  input  logic wait_i,
  output logic done_o,
  output logic timeout_o
);

  logic [WAIT_CTR_W-1:0] cnt_q, cnt_d;
  logic [WAIT_CTR_W-1:0] tmo_q, tmo_d;

  assign done_o    = (cnt_q == '0);
  assign timeout_o = (tmo_q == WAIT_CTR_W'(TIMEOUT));

  // Load on strobe entry, then count down; extend only once at zero.
  always_comb begin
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    if (load_i) begin
      cnt_d = WAIT_CTR_W'(WAIT_STATES);
      tmo_d = '0;
    end else if (run_i) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (wait_i && !timeout_o) begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

endmodule

// File: rtl/mem_cycle_sequencer.sv
// Sequences SETUP/STROBE/HOLD bus cycles for a 2->4 chip-select decoder.
// Define MEM_SEQ_WAIT_EN to add the N_WAIT port and timeout handling.
module mem_cycle_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [DEV_W-1:0]  sel,
  output logic              N_SEL_EN,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              N_OE,
  output logic              N_WE,
  output logic [DATA_W-1:0] bus_dout,
  output logic              bus_doe,
  input  logic [DATA_W-1:0] bus_din
`ifdef MEM_SEQ_WAIT_EN
  ,
  input  logic              N_WAIT
`endif
);

  state_e state_q, state_d;

  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic [DEV_W-1:0]  sel_q, sel_d;
  logic              n_sel_en_q, n_sel_en_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              n_oe_q, n_oe_d;
  logic              n_we_q, n_we_d;
  logic [DATA_W-1:0] bus_dout_q, bus_dout_d;
  logic              bus_doe_q, bus_doe_d;
  logic              wr_q, wr_d;

  logic accept;
  logic wait_w;
  logic done;
  logic tmo;
  logic err_w;

  assign accept = req_valid && req_ready_q;

`ifdef MEM_SEQ_WAIT_EN
  assign wait_w = !N_WAIT;
`else
  assign wait_w = 1'b0;
`endif

  mem_seq_wait_ctr #(
    .WAIT_STATES(WAIT_STATES),
    .TIMEOUT    (TIMEOUT)
  ) u_wait_ctr (
    .clk      (clk),
    .rst      (rst),
    .load_i   (state_q == SETUP),
    .run_i    (state_q == STROBE),
    .wait_i   (wait_w),
    .done_o   (done),
    .timeout_o(tmo)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: leave STROBE once base strobes done and no wait pending.
  always_comb begin
    state_d = state_q;
    err_w   = 1'b0;
    unique case (state_q)
      IDLE:   if (accept) state_d = SETUP;
      SETUP:  state_d = STROBE;
      STROBE: begin
        if (done && !(wait_w && !tmo)) begin
          state_d = HOLD;
          err_w   = wait_w && tmo;
        end
      end
      HOLD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output is registered.
  always_comb begin
    wr_d         = accept ? req_write : wr_q;
    bus_addr_d   = accept ? req_addr : bus_addr_q;
    sel_d        = accept ? req_addr[ADDR_W-1 -: DEV_W] : sel_q;
    bus_dout_d   = accept ? req_wdata : bus_dout_q;
    req_ready_d  = (state_d == IDLE);
    n_sel_en_d   = (state_d == IDLE);
    n_oe_d       = !((state_d == STROBE) && !wr_d);
    n_we_d       = !((state_d == STROBE) && wr_d);
    bus_doe_d    = (state_d != IDLE) && wr_d;
    resp_valid_d = (state_d == HOLD);
    resp_err_d   = (state_d == HOLD) && err_w;
    resp_rdata_d = resp_rdata_q;
    if (state_q == STROBE && state_d == HOLD && !wr_q) begin
      resp_rdata_d = bus_din;
    end
  end

  // Output and request-latch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q         <= 1'b0;
      bus_addr_q   <= '0;
      sel_q        <= '0;
      bus_dout_q   <= '0;
      req_ready_q  <= 1'b1;
      n_sel_en_q   <= 1'b1;
      n_oe_q       <= 1'b1;
      n_we_q       <= 1'b1;
      bus_doe_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      wr_q         <= wr_d;
      bus_addr_q   <= bus_addr_d;
      sel_q        <= sel_d;
      bus_dout_q   <= bus_dout_d;
      req_ready_q  <= req_ready_d;
      n_sel_en_q   <= n_sel_en_d;
      n_oe_q       <= n_oe_d;
      n_we_q       <= n_we_d;
      bus_doe_q    <= bus_doe_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign sel        = sel_q;
  assign N_SEL_EN   = n_sel_en_q;
  assign bus_addr   = bus_addr_q;
  assign N_OE       = n_oe_q;
  assign N_WE       = n_we_q;
  assign bus_dout   = bus_dout_q;
  assign bus_doe    = bus_doe_q;

endmodule

// File: tb/tb_mem_cycle_sequencer.sv
// Self-checking bench for mem_cycle_sequencer.
// Phase-count model compared every cycle, plus literal checks per scenario.
module tb_mem_cycle_sequencer;
  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int WS  = 1;
  localparam int TMO = 15;
  localparam int S   = 1 + WS;
`ifdef MEM_SEQ_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          req_write = 1'b0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic [1:0]    sel;
  logic          n_sel_en;
  logic [AW-1:0] bus_addr;
  logic          n_oe;
  logic          n_we;
  logic [DW-1:0] bus_dout;
  logic          bus_doe;
  logic [DW-1:0] bus_din = '0;
  logic          n_wait = 1'b1;
  logic          wait_low;

  assign wait_low = WAIT_EN && !n_wait;

  always #5 clk = ~clk;

  mem_cycle_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .sel(sel), .N_SEL_EN(n_sel_en), .bus_addr(bus_addr),
    .N_OE(n_oe), .N_WE(n_we), .bus_dout(bus_dout), .bus_doe(bus_doe),
    .bus_din(bus_din)
`ifdef MEM_SEQ_WAIT_EN
    , .N_WAIT(n_wait)
`endif
  );

  int cmp = 0;
  int bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: ph 0 idle, 1 setup, 2 strobe, 3 hold.
  int            cyc = 0;
  int            ph = 0;
  int            sc = 0;
  int            ext = 0;
  int            acc_edge = 0;
  bit            chk_en = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic          m_wr = 1'b0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  logic          m_err = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      ph = 0; m_addr = '0; m_wr = 1'b0; m_wdata = '0;
      m_rdata = '0; m_err = 1'b0; chk_en = 1'b1;
    end else begin
      case (ph)
        0: if (req_valid) begin
          ph = 1; m_addr = req_addr; m_wr = req_write;
          m_wdata = req_wdata; acc_edge = cyc;
        end
        1: begin ph = 2; sc = 1; ext = 0; end
        2: begin
          if (sc < S) sc++;
          else if (wait_low && ext < TMO) ext++;
          else begin
            if (!m_wr) m_rdata = bus_din;
            m_err = wait_low;
            ph = 3;
          end
        end
        default: ph = 0;
      endcase
    end
  end

  // Per-cycle comparison against the model, plus activity counters.
  int nsel_low = 0, noe_low = 0, nwe_low = 0, doe_cnt = 0;
  int resp_cnt = 0, last_resp = 0, prev_resp = 0, err_seen = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", req_ready, ph == 0);
      chk("N_SEL_EN", n_sel_en, ph == 0);
      chk("N_OE", n_oe, !(ph == 2 && !m_wr));
      chk("N_WE", n_we, !(ph == 2 && m_wr));
      chk("bus_doe", bus_doe, ph != 0 && m_wr);
      chk("resp_valid", resp_valid, ph == 3);
      chk("resp_err", resp_err, ph == 3 && m_err);
      chk("resp_rdata", resp_rdata, m_rdata);
      chk("sel", sel, m_addr[AW-1 -: 2]);
      chk("bus_addr", bus_addr, m_addr);
      chk("bus_dout", bus_dout, m_wdata);
    end
    if (!n_sel_en) nsel_low++;
    if (!n_oe) noe_low++;
    if (!n_we) nwe_low++;
    if (bus_doe) doe_cnt++;
    if (resp_valid) begin
      resp_cnt++;
      prev_resp = last_resp;
      last_resp = cyc + 1;
      if (resp_err) err_seen++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    nsel_low = 0; noe_low = 0; nwe_low = 0; doe_cnt = 0;
    resp_cnt = 0; err_seen = 0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin step(); n++; end
    if (n == 20) chk("ready_timeout", 0, 1);
  endtask

  task automatic issue(logic [AW-1:0] a, logic w, logic [DW-1:0] d);
    wait_ready();
    req_addr = a; req_write = w; req_wdata = d; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    // Reset held two cycles.
    rst = 1'b1;
    step(); step();
    chk("rst_ready", req_ready, 1);
    chk("rst_nsel", n_sel_en, 1);
    chk("rst_resp", resp_valid, 0);
    chk("rst_addr", bus_addr, 0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", req_ready, 1);

    // Read with one wait state.
    bus_din = 8'h5A;
    clr();
    issue(16'hC012, 1'b0, 8'h00);
    repeat (6) step();
    chk("rd_nsel_low", nsel_low, 4);
    chk("rd_noe_low", noe_low, 2);
    chk("rd_nwe_low", nwe_low, 0);
    chk("rd_resp_cnt", resp_cnt, 1);
    chk("rd_latency", last_resp - acc_edge, 4);
    chk("rd_rdata", resp_rdata, 8'h5A);
    chk("rd_sel", sel, 2'b11);

    // Write; read data must stay held.
    bus_din = 8'hFF;
    clr();
    issue(16'h4000, 1'b1, 8'hA5);
    repeat (6) step();
    chk("wr_nwe_low", nwe_low, 2);
    chk("wr_noe_low", noe_low, 0);
    chk("wr_doe_cnt", doe_cnt, 4);
    chk("wr_resp_cnt", resp_cnt, 1);
    chk("wr_sel", sel, 2'b01);
    chk("wr_dout", bus_dout, 8'hA5);
    chk("wr_rdata_held", resp_rdata, 8'h5A);

    // Back-to-back with req_valid held; inputs change after first accept.
    clr();
    wait_ready();
    bus_din = 8'h3C;
    req_addr = 16'h8001; req_write = 1'b0; req_valid = 1'b1;
    step();
    req_addr = 16'h0002; req_write = 1'b1; req_wdata = 8'h77;
    repeat (5) step();
    req_valid = 1'b0;
    repeat (6) step();
    chk("b2b_resp_cnt", resp_cnt, 2);
    chk("b2b_spacing", last_resp - prev_resp, 5);
    chk("b2b_nsel_low", nsel_low, 8);
    chk("b2b_rdata", resp_rdata, 8'h3C);
    chk("b2b_dout", bus_dout, 8'h77);

    // Reset during STROBE.
    clr();
    issue(16'h4321, 1'b0, 8'h00);
    begin
      int n = 0;
      while (n_oe && n < 10) begin step(); n++; end
      if (n == 10) chk("strobe_timeout", 0, 1);
    end
    rst = 1'b1;
    step();
    chk("mid_rst_noe", n_oe, 1);
    chk("mid_rst_nsel", n_sel_en, 1);
    chk("mid_rst_resp", resp_valid, 0);
    rst = 1'b0;
    repeat (6) step();
    chk("mid_rst_no_resp", resp_cnt, 0);

`ifdef MEM_SEQ_WAIT_EN
    // Three extensions, no error.
    clr();
    bus_din = 8'h11;
    issue(16'h2000, 1'b0, 8'h00);
    n_wait = 1'b0;
    repeat (5) step();
    n_wait = 1'b1;
    repeat (6) step();
    chk("wt_noe_low", noe_low, 5);
    chk("wt_resp_cnt", resp_cnt, 1);
    chk("wt_err", err_seen, 0);
    chk("wt_rdata", resp_rdata, 8'h11);

    // Stuck wait: timeout with error.
    clr();
    bus_din = 8'h22;
    n_wait = 1'b0;
    issue(16'h2004, 1'b0, 8'h00);
    repeat (25) step();
    n_wait = 1'b1;
    step();
    chk("to_noe_low", noe_low, 17);
    chk("to_resp_cnt", resp_cnt, 1);
    chk("to_err", err_seen, 1);
    chk("to_rdata", resp_rdata, 8'h22);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
